// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS_System memory-side blocks.
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths.
//   TAG_I / TAG_D           : response-routing tags kept in the arbiter
//                             tag FIFO (which requester issued a read).
//   sel_e                   : which requester currently drives the memory port.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: 1-bit wide tag FIFO recording which requester owns each
// outstanding read, oldest first.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO).
//   push       : append push_tag (ignored when full).
//   push_tag   : tag to append.
//   pop        : drop the head entry (ignored when empty).
//   head_tag   : tag of the oldest entry (meaningless when empty).
//   full/empty : occupancy flags.
//   count      : number of entries held.
module arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         push_tag,
  input  logic                         pop,
  output logic                         head_tag,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so that non-power-of-two depths would also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign head_tag = tag_mem[rd_ptr_reg];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Tag storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_mem[wr_ptr_reg] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// (I, read-only) and load/store (D). D wins ties unless I has already watched
// MAX_D_STREAK consecutive D grants, in which case I is forced through. Reads
// return in order; a tag FIFO steers each response to its issuer.
//   clk, reset           : clock, synchronous active-high reset.
//   i_req/i_addr         : fetch request, held until i_gnt.
//   i_gnt/i_rvalid/i_rdata : fetch accept, response valid, response data.
//   d_req/d_we/d_be/d_addr/d_wdata : load/store request, held until d_gnt.
//   d_gnt/d_rvalid/d_rdata : load/store accept, load response valid/data.
//   m_req/m_we/m_be/m_addr/m_wdata/m_gnt : request side of the memory port.
//   m_rvalid/m_rdata     : in-order read responses from memory.
//   out_cnt              : reads currently outstanding at the memory.
//   err                  : sticky, a response arrived with nothing outstanding.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_OUT      = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  output logic                           i_gnt,
  output logic                           i_rvalid,
  output logic [DATA_W-1:0]              i_rdata,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [DATA_W/8-1:0]            d_be,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [DATA_W-1:0]              d_wdata,
  output logic                           d_gnt,
  output logic                           d_rvalid,
  output logic [DATA_W-1:0]              d_rdata,
  output logic                           m_req,
  output logic                           m_we,
  output logic [DATA_W/8-1:0]            m_be,
  output logic [ADDR_W-1:0]              m_addr,
  output logic [DATA_W-1:0]              m_wdata,
  input  logic                           m_gnt,
  input  logic                           m_rvalid,
  input  logic [DATA_W-1:0]              m_rdata,
  output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
  output logic                           err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int CNT_W    = $clog2(MAX_OUT + 1);

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_push;
  logic                fifo_pop;
  logic                push_tag;

  logic                i_elig;
  logic                d_elig;
  logic                streak_max;
  sel_e                sel;

  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                err_reg;
  logic                err_next;

  // A full FIFO blocks reads only, and is judged on the registered count so a
  // same-cycle pop never unblocks a read.
  assign i_elig     = i_req & ~fifo_full;
  assign d_elig     = d_req & (d_we | ~fifo_full);
  assign streak_max = (streak_reg == STREAK_W'(MAX_D_STREAK));

  always_comb begin
    sel = SEL_I;
    if (d_elig && (!i_elig || !streak_max)) begin
      sel = SEL_D;
    end
  end

  assign m_req   = ~reset & (i_elig | d_elig);
  assign i_gnt   = m_req & m_gnt & (sel == SEL_I);
  assign d_gnt   = m_req & m_gnt & (sel == SEL_D);

  assign m_addr  = (sel == SEL_D) ? d_addr  : i_addr;
  assign m_we    = (sel == SEL_D) ? d_we    : 1'b0;
  assign m_be    = (sel == SEL_D) ? d_be    : '1;
  assign m_wdata = (sel == SEL_D) ? d_wdata : '0;

  // Only reads are tracked; stores never produce a response.
  assign fifo_push = i_gnt | (d_gnt & ~d_we);
  assign push_tag  = (sel == SEL_D) ? TAG_D : TAG_I;
  assign fifo_pop  = m_rvalid & ~fifo_empty & ~reset;

  arb_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_tag (push_tag),
    .pop      (fifo_pop),
    .head_tag (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Zero-latency routing: data is shared, the valid is steered by the head tag.
  assign i_rvalid = fifo_pop & (fifo_head == TAG_I);
  assign d_rvalid = fifo_pop & (fifo_head == TAG_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign out_cnt  = fifo_count;
  assign err      = err_reg;

  // Streak counts D grants that I had to watch; it only matters while I waits.
  always_comb begin
    streak_next = streak_reg;
    if (!i_req || i_gnt) begin
      streak_next = '0;
    end else if (d_gnt && !streak_max) begin
      streak_next = streak_reg + 1'b1;
    end
  end

  assign err_next = err_reg | (m_rvalid & fifo_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      streak_reg <= streak_next;
      err_reg    <= err_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against mem_port_arbiter with a
// queue-based reference model checked every cycle, a simple in-order memory
// model on the memory port, and literal expectations for key scenarios.
module tb_mem_port_arbiter;
  import mips_pkg::*;

  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int MAX_OUT      = 2;
  localparam int MAX_D_STREAK = 4;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    out_cnt;
  logic          err;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MAX_OUT      (MAX_OUT),
    .MAX_D_STREAK (MAX_D_STREAK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .out_cnt  (out_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Memory model state.
  logic [31:0] mem [32];
  logic [31:0] rsp_data_q [$];
  int          rsp_due_q [$];
  bit          mem_hold  = 1'b0;
  bit          inject_rv = 1'b0;

  // Arbiter reference model state.
  bit          tag_q [$];      // 0 = fetch issued the read, 1 = load issued it
  int          m_streak = 0;
  bit          m_err    = 1'b0;
  string       gnt_log  = "";
  logic [31:0] i_resp_q [$];
  logic [31:0] d_resp_q [$];

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'hC0DE_0000 | 32'(k);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string name, input string exp);
    checks++;
    if (gnt_log != exp) begin
      errors++;
      $display("FAIL %s: grant order got '%s' required '%s'", name, gnt_log, exp);
    end
  endtask

  task automatic chk_resp(input string name, input bit is_d, input logic [31:0] exp);
    logic [31:0] got;
    checks++;
    if ((is_d && d_resp_q.size() == 0) || (!is_d && i_resp_q.size() == 0)) begin
      errors++;
      $display("FAIL %s: got no response required %h", name, exp);
    end else begin
      if (is_d) got = d_resp_q.pop_front();
      else      got = i_resp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", name, got, exp);
      end
    end
  endtask

  // Per-cycle compare, memory acceptance and model update, all at negedge
  // where inputs (changed just after posedge) and DUT outputs are stable.
  always @(negedge clk) begin : cmp_blk
    bit ie, de, sel_d, e_mreq, e_ig, e_dg, e_irv, e_drv;
    int outn;
    if (cyc > 0) begin
      outn   = tag_q.size();
      ie     = i_req && (outn < MAX_OUT);
      de     = d_req && (d_we || outn < MAX_OUT);
      sel_d  = de && !(ie && m_streak == MAX_D_STREAK);
      e_mreq = !reset && (ie || de);
      e_ig   = e_mreq && m_gnt && !sel_d;
      e_dg   = e_mreq && m_gnt && sel_d;
      e_irv  = !reset && m_rvalid && outn > 0 && tag_q[0] == 1'b0;
      e_drv  = !reset && m_rvalid && outn > 0 && tag_q[0] == 1'b1;

      chk("m_req", 32'(m_req), 32'(e_mreq));
      chk("i_gnt", 32'(i_gnt), 32'(e_ig));
      chk("d_gnt", 32'(d_gnt), 32'(e_dg));
      chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
      chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
      chk("out_cnt", 32'(out_cnt), 32'(outn));
      chk("err", 32'(err), 32'(m_err));
      if (e_mreq) begin
        chk("m_addr", m_addr, sel_d ? d_addr : i_addr);
        chk("m_we", 32'(m_we), 32'(sel_d && d_we));
        chk("m_be", 32'(m_be), sel_d ? 32'(d_be) : 32'hF);
        if (sel_d && d_we) chk("m_wdata", m_wdata, d_wdata);
      end
      if (e_irv) chk("i_rdata", i_rdata, m_rdata);
      if (e_drv) chk("d_rdata", d_rdata, m_rdata);

      // Memory side: accept what the DUT actually presents.
      if (reset) begin
        rsp_data_q.delete();
        rsp_due_q.delete();
      end else if (m_req && m_gnt) begin
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mem[m_addr[6:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          rsp_data_q.push_back(mem[m_addr[6:2]]);
          rsp_due_q.push_back(cyc + 1);
        end
      end

      if (e_ig) begin
        gnt_log = {gnt_log, "I"};
        $display("cyc %0d: grant I read  addr=%h", cyc, i_addr);
      end
      if (e_dg) begin
        gnt_log = {gnt_log, d_we ? "S" : "D"};
        $display("cyc %0d: grant D %s addr=%h", cyc, d_we ? "store" : "load ", d_addr);
      end
      if (i_rvalid) begin
        i_resp_q.push_back(i_rdata);
        $display("cyc %0d: resp  I data=%h", cyc, i_rdata);
      end
      if (d_rvalid) begin
        d_resp_q.push_back(d_rdata);
        $display("cyc %0d: resp  D data=%h", cyc, d_rdata);
      end

      if (reset) begin
        tag_q.delete();
        m_streak = 0;
        m_err    = 1'b0;
      end else begin
        if (m_rvalid) begin
          if (outn > 0) void'(tag_q.pop_front());
          else          m_err = 1'b1;
        end
        if (e_ig) tag_q.push_back(1'b0);
        if (e_dg && !d_we) tag_q.push_back(1'b1);
        if (!i_req || e_ig) m_streak = 0;
        else if (e_dg && m_streak < MAX_D_STREAK) m_streak++;
      end
    end
  end

  // Response driver: in-order, at least one cycle after acceptance.
  always @(posedge clk) begin
    #2;
    if (!mem_hold && rsp_data_q.size() > 0 && rsp_due_q[0] <= cyc) begin
      m_rvalid = 1'b1;
      m_rdata  = rsp_data_q.pop_front();
      void'(rsp_due_q.pop_front());
    end else if (inject_rv) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hDEAD_BEEF;
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i_fetch(input logic [31:0] a);
    bit got;
    got    = 1'b0;
    i_req  = 1'b1;
    i_addr = a;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = i_gnt;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL i_gnt_timeout: got no grant for addr %h required grant within 40 cycles", a);
    end
    step(1);
    i_req = 1'b0;
  endtask

  task automatic d_access(input bit we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
    bit got;
    got     = 1'b0;
    d_req   = 1'b1;
    d_we    = we;
    d_be    = be;
    d_addr  = a;
    d_wdata = wd;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = d_gnt;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL d_gnt_timeout: got no grant for addr %h required grant within 40 cycles", a);
    end
    step(1);
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'hF;
    d_addr  = '0;
    d_wdata = '0;
    m_gnt   = 1'b1;
    m_rvalid = 1'b0;
    m_rdata  = '0;

    // Reset state.
    step(2);
    @(negedge clk);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step(1);
    reset = 1'b0;

    // 1: lone fetch, response one cycle later.
    i_fetch(32'h10);
    step(3);
    chk_resp("t1_i_data", 1'b0, 32'hC0DE_0004);

    // 2: simultaneous fetch and load: D first, responses routed D then I.
    gnt_log = "";
    fork
      i_fetch(32'h20);
      d_access(1'b0, 4'hF, 32'h30, 32'h0);
    join
    step(3);
    chk_log("t2_order", "DI");
    chk_resp("t2_d_data", 1'b1, 32'hC0DE_000C);
    chk_resp("t2_i_data", 1'b0, 32'hC0DE_0008);

    // 3: load stream against waiting fetches: I forced after 4 D grants.
    gnt_log = "";
    fork
      begin
        for (int k = 0; k < 10; k++) d_access(1'b0, 4'hF, 32'(4 * k), 32'h0);
      end
      begin
        i_fetch(32'h100);
        i_fetch(32'h104);
      end
    join
    step(3);
    chk_log("t3_streak", "DDDDIDDDDIDD");
    i_resp_q.delete();
    d_resp_q.delete();

    // 4: two reads outstanding block a third; a store still passes.
    gnt_log  = "";
    mem_hold = 1'b1;
    d_access(1'b0, 4'hF, 32'h44, 32'h0);
    d_access(1'b0, 4'hF, 32'h48, 32'h0);
    fork
      i_fetch(32'h4C);
      begin
        @(negedge clk);
        chk("t4_blocked_mreq", 32'(m_req), 32'd0);
        chk("t4_full_cnt", 32'(out_cnt), 32'd2);
        step(1);
        d_access(1'b1, 4'b0011, 32'h40, 32'h1234_5678);
        mem_hold = 1'b0;
      end
    join
    step(4);
    chk_log("t4_order", "DDSI");
    chk_resp("t4_d0", 1'b1, 32'hC0DE_0011);
    chk_resp("t4_d1", 1'b1, 32'hC0DE_0012);
    chk_resp("t4_i", 1'b0, 32'hC0DE_0013);
    d_access(1'b0, 4'hF, 32'h40, 32'h0);
    step(3);
    chk_resp("t4_store_rb", 1'b1, 32'hC0DE_5678);

    // 5: spurious response sets sticky err; reset clears it.
    inject_rv = 1'b1;
    step(1);
    inject_rv = 1'b0;
    step(2);
    @(negedge clk);
    chk("t5_err_set", 32'(err), 32'd1);
    step(3);
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_no_resp", 32'(i_resp_q.size() + d_resp_q.size()), 32'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_err_clr", 32'(err), 32'd0);
    step(1);

    // 6: reset with two reads outstanding discards them.
    mem_hold = 1'b1;
    fork
      i_fetch(32'h08);
      d_access(1'b0, 4'hF, 32'h0C, 32'h0);
    join
    @(negedge clk);
    chk("t6_cnt_before", 32'(out_cnt), 32'd2);
    step(1);
    reset  = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h14;
    @(negedge clk);
    chk("t6_rst_mreq", 32'(m_req), 32'd0);
    chk("t6_rst_ignt", 32'(i_gnt), 32'd0);
    step(1);
    @(negedge clk);
    chk("t6_rst_cnt", 32'(out_cnt), 32'd0);
    step(1);
    reset    = 1'b0;
    mem_hold = 1'b0;
    i_resp_q.delete();
    d_resp_q.delete();
    i_fetch(32'h14);
    step(3);
    chk_resp("t6_fetch", 1'b0, 32'hC0DE_0005);
    chk("t6_no_stale", 32'(i_resp_q.size() + d_resp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port of the pipelined MIPS_System between the instruction-fetch (I) requester and the load/store (D) requester. D has priority over I, bounded by a starvation counter. Read responses return in order, and an internal tag FIFO routes each response to the requester that issued it. Sits between the pipeline's IF/MEM stages and the unified instruction/data memory and MMIO decoder.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, data width in bits.
MAX_OUT, 2, maximum number of reads outstanding at the memory (tag FIFO depth, power of 2, >=1).
MAX_D_STREAK, 4, consecutive D grants allowed while I waits before I is forced through.

Ports:
clk  in  1  system clock, single domain.
reset  in  1  synchronous, active-high.
i_req  in  1  fetch read request; held with i_addr until i_gnt.
i_addr  in  ADDR_W  fetch address.
i_gnt  out  1  fetch request accepted this cycle.
i_rvalid  out  1  fetch read data valid.
i_rdata  out  DATA_W  fetch read data.
d_req  in  1  load/store request; held with its fields until d_gnt.
d_we  in  1  1 = store, 0 = load.
d_be  in  DATA_W/8  byte enables for stores.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_gnt  out  1  data request accepted this cycle.
d_rvalid  out  1  load data valid.
d_rdata  out  DATA_W  load data.
m_req  out  1  request to memory.
m_we  out  1  write enable to memory.
m_be  out  DATA_W/8  byte enables to memory.
m_addr  out  ADDR_W  address to memory.
m_wdata  out  DATA_W  write data to memory.
m_gnt  in  1  memory accepts the current m_req.
m_rvalid  in  1  read response valid (in order, >=1 cycle after acceptance).
m_rdata  in  DATA_W  read response data.
out_cnt  out  clog2(MAX_OUT+1)  reads currently outstanding.
err  out  1  sticky: m_rvalid arrived with no read outstanding.

Behaviour:
- Reset (synchronous, active-high): out_cnt=0, tag FIFO empty, streak=0, err=0. While reset is high, m_req, i_gnt, d_gnt, i_rvalid and d_rvalid are forced to 0. Memory shares the same reset.
- Selection (combinational, every cycle):
  - Eligible = req high, and either the access is a store or out_cnt < MAX_OUT. A full FIFO blocks reads only; a pop in the same cycle does not unblock a read.
  - Only one requester eligible: it is selected.
  - Both eligible: D is selected unless streak == MAX_D_STREAK, in which case I is selected.
- m_req = any requester selected. m_addr/m_we/m_be/m_wdata are muxed from the selected requester. For I: m_we=0, m_be all-ones.
- Grants: i_gnt/d_gnt = m_req & m_gnt & (selected == that requester). Zero-wait grant when m_gnt is already high. A requester must not change its fields while req is high and gnt is low.
- Streak counter:
  - Increments (saturating at MAX_D_STREAK) on a D grant while i_req is high.
  - Clears on an I grant or whenever i_req is low.
- Tag FIFO:
  - Push on any granted read; tag 0 = I, tag 1 = D.
  - Pop on m_rvalid.
  - Push and pop in the same cycle leave out_cnt unchanged.
  - Pointers wrap modulo MAX_OUT.
- Response routing:
  - i_rvalid = m_rvalid & head tag I; d_rvalid = m_rvalid & head tag D.
  - i_rdata and d_rdata both equal m_rdata, combinationally; data is valid only with the matching rvalid.
  - Response latency through the arbiter is 0 cycles.
- Stores: no response, nothing pushed, out_cnt unaffected. Stores may be issued while reads are outstanding. Memory guarantees read-after-write ordering at its port.
- Boundary cases:
  - m_rvalid with FIFO empty: err<=1 (sticky until reset), no pop, both rvalids 0.
  - MAX_OUT==1: strictly one read in flight.
  - Reset mid-transaction: outstanding tags are discarded; responses in flight are the memory's responsibility to squash.

Decomposition:
- Shared package mips_pkg: ADDR_W/DATA_W defaults, tag constants TAG_I=1'b0 and TAG_D=1'b1.
- One sub-module arb_tag_fifo: 1-bit wide, depth MAX_OUT, push/pop/full/empty/count, synchronous reset.
- Selection and streak logic stay in the top module.

Test Plan:
- I only, m_gnt=1, response 1 cycle later: i_gnt same cycle; i_rvalid and i_rdata match 1 cycle later; out_cnt pulses 1 then returns to 0.
- i_req and d_req (load) together: D granted first, I next cycle; responses route with tag order D then I.
- d_req continuous loads plus i_req high, MAX_D_STREAK=4: grants DDDD I DDDD I; I never waits more than 4 grant cycles.
- Hold m_rvalid low after 2 reads (MAX_OUT=2): third read is blocked, m_req=0. A store presented meanwhile is granted. A pop then unblocks the read next cycle.
- Inject m_rvalid with out_cnt=0: err=1 and stays 1; no rvalid out. reset clears err.
- Assert reset with 2 reads outstanding: next cycle out_cnt=0, no gnts; normal fetch resumes after reset drops.
